// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: arbiter state encoding, owner encoding and
// fixed constants for the TPU register-slave port.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_EXT
    } owner_e;

    // Read data returned to the owner when a stalled access is aborted
    localparam logic [31:0] TPU_ARB_ERR_DATA = 32'hDEAD_BEEF;

    // Base address of the TPU register block in the SoC map
    localparam logic [31:0] TPU_REG_BASE = 32'h0000_1000;

endpackage

// File: rtl/tpu_bus_arbiter_rr_pick2.sv
// Two-requester round-robin select. On a tie the master that did not own
// the bus last time wins; a single request is always granted.
import soc_bus_pkg::*;

module rr_pick2 (
    input  logic   req_cpu,
    input  logic   req_ext,
    input  owner_e last_owner,
    output logic   gnt_valid,
    output logic   gnt_ext
);

    // Pure combinational pick; the caller registers the result
    always_comb begin
        gnt_valid = req_cpu | req_ext;
        gnt_ext   = req_ext & (~req_cpu | (last_owner == OWN_CPU));
    end

endmodule

// File: rtl/tpu_bus_arbiter.sv
// Round-robin arbiter sharing the TPU register-slave port between the CPU
// MMIO path and the external host interface. One transaction in flight;
// every target-side signal is registered.
// Optional build macro TPU_ARB_TIMEOUT_EN: aborts a BUSY access after
// TIMEOUT_CYCLES cycles without tgt_ready, returning TPU_ARB_ERR_DATA on
// reads and pulsing bus_err together with the owner's ready.
import soc_bus_pkg::*;

module tpu_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    // CPU master
    input  logic              cpu_sel,
    input  logic              cpu_wen,
    input  logic              cpu_ren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    // External host master
    input  logic              ext_sel,
    input  logic              ext_wen,
    input  logic              ext_ren,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ready,
    // TPU register slave
    output logic              tgt_sel,
    output logic              tgt_wen,
    output logic              tgt_ren,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic [DATA_W-1:0] tgt_wdata,
    input  logic [DATA_W-1:0] tgt_rdata,
    input  logic              tgt_ready,
    // Status
    output logic              grant_ext,
    output logic              arb_busy,
    output logic              bus_err
);

    arb_state_e state;
    owner_e     last_owner;
    logic       cpu_req;
    logic       ext_req;
    logic       gnt_valid;
    logic       gnt_ext;
    logic       tmo_hit;
    logic       bus_err_q;

    // A select without any strobe is not a request
    assign cpu_req = cpu_sel & (cpu_wen | cpu_ren);
    assign ext_req = ext_sel & (ext_wen | ext_ren);

    rr_pick2 u_pick (
        .req_cpu    (cpu_req),
        .req_ext    (ext_req),
        .last_owner (last_owner),
        .gnt_valid  (gnt_valid),
        .gnt_ext    (gnt_ext)
    );

`ifdef TPU_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Count BUSY cycles spent waiting on the slave; cleared while IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if ((state == BUSY) && !tgt_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A real completion on the abort edge wins over the timeout
    assign tmo_hit = (state == BUSY) && !tgt_ready && (tmo_cnt == TMO_LAST);
    assign bus_err = bus_err_q;
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign tmo_hit            = 1'b0;
    assign bus_err            = 1'b0;
`endif

    assign arb_busy = (state != IDLE);

    // Arbitration FSM with registered target handshake and per-master responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWN_EXT;
            grant_ext  <= 1'b0;
            tgt_sel    <= 1'b0;
            tgt_wen    <= 1'b0;
            tgt_ren    <= 1'b0;
            tgt_addr   <= '0;
            tgt_wdata  <= '0;
            cpu_rdata  <= '0;
            ext_rdata  <= '0;
            cpu_ready  <= 1'b0;
            ext_ready  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            ext_ready <= 1'b0;
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        if (gnt_ext) begin
                            tgt_addr   <= ext_addr;
                            tgt_wdata  <= ext_wdata;
                            tgt_wen    <= ext_wen;
                            tgt_ren    <= ext_ren & ~ext_wen;
                            last_owner <= OWN_EXT;
                            grant_ext  <= 1'b1;
                        end else begin
                            tgt_addr   <= cpu_addr;
                            tgt_wdata  <= cpu_wdata;
                            tgt_wen    <= cpu_wen;
                            tgt_ren    <= cpu_ren & ~cpu_wen;
                            last_owner <= OWN_CPU;
                            grant_ext  <= 1'b0;
                        end
                        tgt_sel <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (tgt_ready || tmo_hit) begin
                        if (tgt_ren) begin
                            if (last_owner == OWN_EXT) begin
                                ext_rdata <= tmo_hit ? DATA_W'(TPU_ARB_ERR_DATA) : tgt_rdata;
                            end else begin
                                cpu_rdata <= tmo_hit ? DATA_W'(TPU_ARB_ERR_DATA) : tgt_rdata;
                            end
                        end
                        ext_ready <= (last_owner == OWN_EXT);
                        cpu_ready <= (last_owner == OWN_CPU);
                        bus_err_q <= tmo_hit;
                        tgt_sel   <= 1'b0;
                        tgt_wen   <= 1'b0;
                        tgt_ren   <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tpu_bus_arbiter.md
Name: tpu_bus_arbiter

Overview:
- Shares the single TPU register-slave port (base 0x1000) between two masters: CPU memory-mapped I/O and the external host interface.
- Fair round-robin grant; one transaction in flight at a time.
- Converts both masters' sel/wen/ren/ready handshakes into one registered target-side handshake.
- Sits between the CPU/ext decode and the TPU register block inside tritone_soc.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- TIMEOUT_CYCLES, 64, BUSY cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cpu_sel / cpu_wen / cpu_ren  in  1 each  CPU request, write strobe, read strobe
- cpu_addr  in  ADDR_W;  cpu_wdata  in  DATA_W
- cpu_rdata  out  DATA_W;  cpu_ready  out  1  one-cycle completion pulse
- ext_sel / ext_wen / ext_ren / ext_addr / ext_wdata / ext_rdata / ext_ready  same shape as cpu_*, for the host
- tgt_sel / tgt_wen / tgt_ren  out  1 each  to TPU register slave
- tgt_addr  out  ADDR_W;  tgt_wdata  out  DATA_W
- tgt_rdata  in  DATA_W;  tgt_ready  in  1  slave done (may be combinational in the same cycle as tgt_sel)
- grant_ext  out  1  current/last owner (0 = CPU, 1 = ext)
- arb_busy  out  1  high whenever the arbiter is not in IDLE
- bus_err  out  1  one-cycle abort pulse

Behaviour:
- Reset (async, rst=1):
  - State IDLE; all outputs 0, including rdata registers.
  - last_owner = EXT, so CPU wins the first tie.
- Valid request: sel && (wen || ren). sel with neither strobe is ignored. wen && ren is treated as a write; tgt_ren is driven 0.
- IDLE:
  - Samples both requests each edge.
  - One valid: grant it.
  - Both valid: grant the master that is not last_owner.
  - On grant: latch addr, wdata and wen/ren into target regs; tgt_sel=1 from the next cycle; update last_owner and grant_ext; go to BUSY.
- BUSY:
  - tgt_* held stable.
  - At an edge with tgt_ready=1: capture tgt_rdata into the owner's rdata register (reads only; on writes the register is unchanged). Drop tgt_sel/wen/ren, go to RESP.
- RESP:
  - The owner's ready is high for exactly this one cycle; the other master's ready stays 0.
  - Next edge: IDLE.
  - The requester drops sel on the edge where it samples ready, so IDLE never re-accepts the finished request.
- Latency:
  - Request seen at edge 0 -> tgt_sel high cycles 0–1.
  - Zero-wait slave -> ready high in cycle 1–2 -> IDLE at edge 2.
  - Minimum 2 cycles per transaction; each slave wait state adds 1.
- Non-owner requests stay pending (no ready) until the next IDLE.
- rdata outputs hold their last captured value; they are meaningful only while ready is high.
- Owner withdraws sel during BUSY (protocol violation): the target transaction still completes and the ready pulse is still issued.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - The in-flight target access is abandoned; the slave must tolerate sel dropping.
- bus_err is 0 in all states unless the optional feature is enabled.

Optional Feature:
- Macro TPU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without tgt_ready.
  - When it reaches TIMEOUT_CYCLES: drop tgt_*; load the owner's rdata with 32'hDEAD_BEEF (reads only); pulse bus_err for one cycle coincident with ready; go to RESP.
  - tgt_ready arriving on the abort edge takes priority as a normal completion.
- Undefined: no counter is instantiated, BUSY waits indefinitely, and bus_err is tied 0.

Decomposition:
- Shared package soc_bus_pkg holds:
  - arb_state_e {IDLE, BUSY, RESP}
  - owner_e {OWN_CPU, OWN_EXT}
  - TPU_ARB_ERR_DATA = 32'hDEAD_BEEF
  - TPU_REG_BASE = 32'h1000
- One sub-module, rr_pick2: combinational round-robin select from two request bits and last_owner. Outputs gnt_valid and gnt_ext.
- FSM and datapath registers stay in tpu_bus_arbiter.

Test Plan:
- Reset released, ext reads 0x1018 with a zero-wait slave returning 0x0000_0820: tgt_sel high 1 cycle after the request; ext_ready pulses exactly once, 2 cycles after the request; ext_rdata = 0x0000_0820; cpu_ready stays 0.
- CPU and ext both write in the same cycle (CPU 0x1014 <- 0x0004_0004, ext 0x1008 <- 0x0000_0000): CPU is served first, then ext; tgt_addr sequence is 0x1014 then 0x1008; grant_ext goes 0 then 1.
- Ext issues 3 back-to-back reads while CPU holds a continuous request: grants alternate ext/CPU/ext/CPU (neither master is starved); every transaction gets exactly one ready pulse.
- Slave inserts 5 wait states on a read of 0x1004: tgt_addr, tgt_ren and tgt_sel are stable for 6 cycles; cpu_ready asserts at cycle 7; rdata equals the slave value.
- rst asserted while in BUSY: all outputs 0 asynchronously; after release, a fresh CPU request wins the tie.
- TPU_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never ready: after 8 BUSY cycles, ext_ready and bus_err pulse together and ext_rdata = 0xDEAD_BEEF. With the macro undefined: no ready pulse within 100 cycles and bus_err stays 0.
